// File: rtl/pgm_sched.sv
// pgm_sched: replays the pgm RAM packet template COUNT times (0 = until stop),
// with GAP idle cycles between packets, under packet-boundary alf backpressure.
// RAM has 1-cycle read latency; the output stage is the registered read strobe
// paired with the RAM data that returns in the following cycle.
module pgm_sched #(
   parameter int ADDR_W = 7,
   parameter int CNT_W  = 32,
   parameter int GAP_W  = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              cfg_wr,
   input  logic [1:0]        cfg_addr,
   input  logic [31:0]       cfg_wdata,
   output logic              sched_busy,
   output logic [CNT_W-1:0]  sent_cnt,
   output logic              out_pgm_sent_start_flag,
   output logic              out_pgm_sent_finish_flag,
   output logic              rd2ram_rd,
   output logic [ADDR_W-1:0] rd2ram_addr,
   input  logic [143:0]      ram2rd_rdata,
   output logic [133:0]      out_pgm_data,
   output logic              out_pgm_data_wr,
   output logic              out_pgm_valid,
   output logic              out_pgm_valid_wr,
   input  logic              in_pgm_alf
);

   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_WAIT = 3'd1;
   localparam logic [2:0] S_READ = 3'd2;
   localparam logic [2:0] S_GAP  = 3'd3;
   localparam logic [2:0] S_DONE = 3'd4;

   localparam logic [ADDR_W:0] LEN_MAX = {1'b1, {ADDR_W{1'b0}}};

   logic [2:0]        state;
   logic [ADDR_W:0]   len_r;
   logic [CNT_W-1:0]  count_r;
   logic [GAP_W-1:0]  gap_r;
   logic [ADDR_W-1:0] addr_q;
   logic [CNT_W-1:0]  rem_q;
   logic [GAP_W-1:0]  gap_cnt;
   logic              stop_pend;
   logic              first_pkt;
   logic              wr_q;
   logic              last_q;
   logic              sflag_q;
   logic [CNT_W-1:0]  sent_q;

   logic ctrl_wr, start_ok, stop_now, stop_eff, last_rd, last_pkt;
   logic unused_rdata;

   assign unused_rdata = ^ram2rd_rdata[143:134];

   assign ctrl_wr  = cfg_wr && (cfg_addr == 2'd3);
   assign start_ok = ctrl_wr && cfg_wdata[0] && (state == S_IDLE) &&
                     (len_r != '0) && (len_r <= LEN_MAX);
   // A stop written in the same cycle as a packet-boundary decision is honoured
   // immediately, so a stop during the last read ends the run on that packet.
   assign stop_now = ctrl_wr && cfg_wdata[1] && (state != S_IDLE);
   assign stop_eff = stop_pend || stop_now;
   assign last_rd  = (state == S_READ) && ({1'b0, addr_q} == len_r - 1'b1);
   assign last_pkt = (count_r != '0) && (rem_q == CNT_W'(1));

   // Config registers; frozen while a run is in progress.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         len_r   <= '0;
         count_r <= '0;
         gap_r   <= '0;
      end else if (cfg_wr && state == S_IDLE) begin
         case (cfg_addr)
            2'd0:    len_r   <= cfg_wdata[ADDR_W:0];
            2'd1:    count_r <= cfg_wdata[CNT_W-1:0];
            2'd2:    gap_r   <= cfg_wdata[GAP_W-1:0];
            default: ;
         endcase
      end
   end

   // Sequencing FSM: packet boundaries, read address walk, gap timing.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= S_IDLE;
         addr_q    <= '0;
         rem_q     <= '0;
         gap_cnt   <= '0;
         first_pkt <= 1'b0;
      end else begin
         case (state)
            S_IDLE: if (start_ok) begin
               state     <= S_WAIT;
               rem_q     <= count_r;
               first_pkt <= 1'b1;
            end
            S_WAIT: begin
               if (stop_eff) state <= S_DONE;
               else if (!in_pgm_alf) begin
                  state  <= S_READ;
                  addr_q <= '0;
               end
            end
            S_READ: begin
               first_pkt <= 1'b0;
               if (last_rd) begin
                  rem_q <= rem_q - CNT_W'(1);
                  if (last_pkt || stop_eff) state <= S_DONE;
                  else if (gap_r == '0)     state <= S_WAIT;
                  else begin
                     state   <= S_GAP;
                     gap_cnt <= gap_r - GAP_W'(1);
                  end
               end else begin
                  addr_q <= addr_q + ADDR_W'(1);
               end
            end
            S_GAP: begin
               if (gap_cnt == '0) state <= S_WAIT;
               else               gap_cnt <= gap_cnt - GAP_W'(1);
            end
            S_DONE:  state <= S_IDLE;
            default: state <= S_IDLE;
         endcase
      end
   end

   // Stop request latch; dropped once the run has ended.
   always_ff @(posedge clk) begin
      if (!rst_n)                                   stop_pend <= 1'b0;
      else if (state == S_DONE || state == S_IDLE)  stop_pend <= 1'b0;
      else if (stop_now)                            stop_pend <= 1'b1;
   end

   // Output strobes trail the read by one cycle to line up with RAM data.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_q    <= 1'b0;
         last_q  <= 1'b0;
         sflag_q <= 1'b0;
      end else begin
         wr_q    <= (state == S_READ);
         last_q  <= last_rd;
         sflag_q <= (state == S_READ) && first_pkt;
      end
   end

   // Completed-packet counter, cleared by an accepted start.
   always_ff @(posedge clk) begin
      if (!rst_n)        sent_q <= '0;
      else if (start_ok) sent_q <= '0;
      else if (last_q)   sent_q <= sent_q + CNT_W'(1);
   end

   assign sched_busy               = (state != S_IDLE);
   assign sent_cnt                 = sent_q;
   assign out_pgm_sent_start_flag  = sflag_q;
   // DONE is entered the cycle after the last read, i.e. with the last word.
   assign out_pgm_sent_finish_flag = (state == S_DONE);
   assign rd2ram_rd                = (state == S_READ);
   assign rd2ram_addr              = addr_q;
   assign out_pgm_data             = wr_q ? ram2rd_rdata[133:0] : '0;
   assign out_pgm_data_wr          = wr_q;
   assign out_pgm_valid            = last_q;
   assign out_pgm_valid_wr         = last_q;

endmodule

// File: tb/tb_pgm_sched.sv
// Bench for pgm_sched: RAM model, cycle-by-cycle timeline model derived from
// the packet period (LEN + GAP + 1), directed and randomized runs.
module tb_pgm_sched;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         cfg_wr;
   logic [1:0]   cfg_addr;
   logic [31:0]  cfg_wdata;
   logic         sched_busy;
   logic [31:0]  sent_cnt;
   logic         sflag, fflag;
   logic         rd;
   logic [6:0]   addr;
   logic [143:0] rdata;
   logic [133:0] data;
   logic         data_wr, valid, valid_wr;
   logic         alf;

   logic [143:0] mem [128];
   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   pgm_sched dut (
      .clk(clk), .rst_n(rst_n), .cfg_wr(cfg_wr), .cfg_addr(cfg_addr),
      .cfg_wdata(cfg_wdata), .sched_busy(sched_busy), .sent_cnt(sent_cnt),
      .out_pgm_sent_start_flag(sflag), .out_pgm_sent_finish_flag(fflag),
      .rd2ram_rd(rd), .rd2ram_addr(addr), .ram2rd_rdata(rdata),
      .out_pgm_data(data), .out_pgm_data_wr(data_wr), .out_pgm_valid(valid),
      .out_pgm_valid_wr(valid_wr), .in_pgm_alf(alf)
   );

   // RAM model: 1-cycle read latency
   always @(posedge clk) if (rd) rdata <= mem[addr];

   task automatic chk(input string tag, input logic [143:0] obs, input logic [143:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s got=%0h exp=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, ".busy"}, sched_busy, 0);
      chk({tag, ".sent"}, sent_cnt, 0);
      chk({tag, ".sflag"}, sflag, 0);
      chk({tag, ".fflag"}, fflag, 0);
      chk({tag, ".rd"}, rd, 0);
      chk({tag, ".addr"}, addr, 0);
      chk({tag, ".data"}, data, 0);
      chk({tag, ".wr"}, data_wr, 0);
      chk({tag, ".valid"}, valid, 0);
      chk({tag, ".vwr"}, valid_wr, 0);
   endtask

   // one-cycle config write; called and returns at a negedge
   task automatic cfg(input logic [1:0] a, input int d);
      cfg_wr = 1'b1; cfg_addr = a; cfg_wdata = d;
      @(negedge clk);
      cfg_wr = 1'b0;
   endtask

   // word index emitted at cycle t after the start write, or -1
   function automatic int widx(input int t, input int len, input int cnt, input int per);
      int off, k, i;
      if (t < 3) return -1;
      off = t - 3; k = off / per; i = off % per;
      if (k < cnt && i < len) return i;
      return -1;
   endfunction

   // full run with alf=0; optional ignored writes (LEN change, restart) mid-run
   task automatic run(input int len, input int cnt, input int gap, input bit interfere);
      int per, tf, exp_sent, wi, ri;
      cfg(0, len); cfg(1, cnt); cfg(2, gap);
      cfg_wr = 1'b1; cfg_addr = 2'd3; cfg_wdata = 32'd1;
      per = len + gap + 1;
      tf  = 3 + (cnt - 1) * per + len - 1;
      exp_sent = 0;
      for (int t = 1; t <= tf + 2; t++) begin
         @(negedge clk);
         cfg_wr = 1'b0;
         if (interfere && t == 5) begin cfg_wr = 1'b1; cfg_addr = 2'd0; cfg_wdata = 32'd7; end
         if (interfere && t == 6) begin cfg_wr = 1'b1; cfg_addr = 2'd3; cfg_wdata = 32'd1; end
         wi = widx(t, len, cnt, per);
         ri = widx(t + 1, len, cnt, per);
         chk("run.wr", data_wr, wi >= 0);
         chk("run.vwr", valid_wr, wi == len - 1);
         chk("run.valid", valid, wi == len - 1);
         chk("run.data", data, (wi >= 0) ? {10'b0, mem[wi][133:0]} : 144'b0);
         chk("run.sflag", sflag, t == 3);
         chk("run.fflag", fflag, t == tf);
         chk("run.busy", sched_busy, t <= tf);
         chk("run.rd", rd, ri >= 0);
         if (ri >= 0) chk("run.addr", addr, ri);
         chk("run.sent", sent_cnt, exp_sent);
         if (wi == len - 1) exp_sent++;
      end
   endtask

   initial begin
      int s, n, tfin, nvw, expf;
      for (int i = 0; i < 128; i++)
         mem[i] = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
      rst_n = 1'b0; cfg_wr = 1'b0; cfg_addr = '0; cfg_wdata = '0; alf = 1'b0;
      @(negedge clk); @(negedge clk);
      chk_zero("reset");
      rst_n = 1'b1;
      @(negedge clk);

      // directed timelines and boundaries
      run(4, 3, 0, 0);
      run(2, 2, 5, 0);
      run(1, 3, 2, 0);
      run(128, 1, 0, 0);
      run(3, 2, 1, 1);
      // randomized configs
      for (int r = 0; r < 5; r++)
         run($urandom_range(1, 12), $urandom_range(1, 4), $urandom_range(0, 4), 0);

      // LEN=0 and LEN>128 starts are dropped
      for (int r = 0; r < 2; r++) begin
         cfg(0, r == 0 ? 0 : 200);
         cfg_wr = 1'b1; cfg_addr = 2'd3; cfg_wdata = 32'd1;
         for (int t = 1; t <= 4; t++) begin
            @(negedge clk);
            cfg_wr = 1'b0;
            chk("badlen.busy", sched_busy, 0);
            chk("badlen.rd", rd, 0);
            chk("badlen.sflag", sflag, 0);
            chk("badlen.fflag", fflag, 0);
         end
      end

      // alf held before start, then raised mid-packet
      cfg(0, 6); cfg(1, 2); cfg(2, 0);
      alf = 1'b1;
      cfg_wr = 1'b1; cfg_addr = 2'd3; cfg_wdata = 32'd1;
      for (int t = 1; t <= 32; t++) begin
         @(negedge clk);
         cfg_wr = 1'b0;
         if (t <= 10) chk("alf.hold_rd", rd, 0);
         chk("alf.wr", data_wr, (t >= 12 && t <= 17) || (t >= 27 && t <= 32));
         chk("alf.sflag", sflag, t == 12);
         chk("alf.fflag", fflag, t == 32);
         if (t == 12) chk("alf.data0", data, {10'b0, mem[0][133:0]});
         if (t == 10) alf = 1'b0;
         if (t == 13) alf = 1'b1;
         if (t == 25) alf = 1'b0;
      end
      @(negedge clk);
      chk("alf.sent", sent_cnt, 2);

      // COUNT=0 with stop: one stop before and one after the 8th packet's first read
      for (int r = 0; r < 2; r++) begin
         s = (r == 0) ? $urandom_range(26, 29) : $urandom_range(30, 33);
         n = (s - 2) / 4 + 1;
         expf = (4 * n + 1 > s + 1) ? 4 * n + 1 : s + 1;
         tfin = -1; nvw = 0;
         cfg(0, 3); cfg(1, 0); cfg(2, 0);
         cfg_wr = 1'b1; cfg_addr = 2'd3; cfg_wdata = 32'd1;
         for (int t = 1; t <= 60 && tfin < 0; t++) begin
            @(negedge clk);
            cfg_wr = 1'b0;
            if (valid_wr) nvw++;
            if (fflag) tfin = t;
            if (t == s) begin cfg_wr = 1'b1; cfg_addr = 2'd3; cfg_wdata = 32'd2; end
         end
         chk("stop.fin_cycle", tfin, expf);
         chk("stop.nvalid", nvw, n);
         @(negedge clk);
         chk("stop.sent", sent_cnt, n);
         chk("stop.busy", sched_busy, 0);
         @(negedge clk);
      end

      // reset mid-packet at word 4 of an 8-word packet
      cfg(0, 8); cfg(1, 1); cfg(2, 0);
      cfg_wr = 1'b1; cfg_addr = 2'd3; cfg_wdata = 32'd1;
      for (int t = 1; t <= 7; t++) begin
         @(negedge clk);
         cfg_wr = 1'b0;
      end
      chk("rst.pre_wr", data_wr, 1);
      chk("rst.pre_data", data, {10'b0, mem[4][133:0]});
      rst_n = 1'b0;
      @(negedge clk);
      chk_zero("rst.mid");
      rst_n = 1'b1;
      for (int t = 0; t < 6; t++) begin
         @(negedge clk);
         chk("rst.after_wr", data_wr, 0);
         chk("rst.after_vwr", valid_wr, 0);
         chk("rst.after_fflag", fflag, 0);
         chk("rst.after_busy", sched_busy, 0);
      end
      run(5, 2, 1, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
